// File: rtl/alu_issue_ctrl_if.sv
// Operand/select handshake bundle between the decode stage, alu_issue_ctrl and the ALU.
// The DUT connects through the slave modport; the driving environment uses master.
interface alu_issue_ctrl_if;
  logic        IN_VALID;
  logic        IN_READY;
  logic [31:0] INSTR;
  logic [31:0] RS1_DATA;
  logic [31:0] RS2_DATA;
  logic [31:0] PC;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [31:0] DATA1;
  logic [31:0] DATA2;
  logic [3:0]  SELECT;
  logic [4:0]  RD;
  logic        WB_EN;
  logic        ILLEGAL;

  modport master (
    output IN_VALID, INSTR, RS1_DATA, RS2_DATA, PC, OUT_READY,
    input  IN_READY, OUT_VALID, DATA1, DATA2, SELECT, RD, WB_EN, ILLEGAL
  );

  modport slave (
    input  IN_VALID, INSTR, RS1_DATA, RS2_DATA, PC, OUT_READY,
    output IN_READY, OUT_VALID, DATA1, DATA2, SELECT, RD, WB_EN, ILLEGAL
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// ID/EX issue stage: decodes RV32 ALU ops into SELECT/DATA1/DATA2 and holds them in a one-entry stage.
// Define ALU_ISSUE_MUL_EN to decode MUL with a MUL_LATENCY-cycle wait (MWAIT) before OUT_VALID.
module alu_issue_ctrl #(
  parameter int unsigned MUL_LATENCY = 3
) (
  input  logic              CLK,
  input  logic              RESETN,
  input  logic              FLUSH,
  alu_issue_ctrl_if.slave   bus
);

  if ((MUL_LATENCY < 1) || (MUL_LATENCY > 15)) begin : g_lat_range
    $error("MUL_LATENCY must be within 1..15");
  end

  typedef enum logic [3:0] {
    SEL_FWD = 4'b0000,
    SEL_ADD = 4'b0001,
    SEL_AND = 4'b0010,
    SEL_OR  = 4'b0011,
    SEL_MUL = 4'b0101,
    SEL_XOR = 4'b0110,
    SEL_SLL = 4'b0111,
    SEL_SRL = 4'b1000,
    SEL_SRA = 4'b1001
  } sel_t;

`ifdef ALU_ISSUE_MUL_EN
  typedef enum logic [1:0] {IDLE, MWAIT, HOLD} state_t;
  localparam logic [3:0] CNT_LOAD = 4'(MUL_LATENCY - 1);
`else
  typedef enum logic [1:0] {IDLE, HOLD} state_t;
`endif

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i;
  logic [31:0] imm_u;
  logic [31:0] shamt;

  assign opcode = bus.INSTR[6:0];
  assign funct3 = bus.INSTR[14:12];
  assign funct7 = bus.INSTR[31:25];
  assign imm_i  = {{20{bus.INSTR[31]}}, bus.INSTR[31:20]};
  assign imm_u  = {bus.INSTR[31:12], 12'b0};
  assign shamt  = {27'b0, bus.INSTR[24:20]};

  sel_t        dec_sel;
  logic [31:0] dec_d1;
  logic [31:0] dec_d2;
  logic        dec_ok;
`ifdef ALU_ISSUE_MUL_EN
  logic        dec_mul;
`endif

  always_comb begin
    dec_sel = SEL_FWD;
    dec_d1  = '0;
    dec_d2  = '0;
    dec_ok  = 1'b0;
`ifdef ALU_ISSUE_MUL_EN
    dec_mul = 1'b0;
`endif
    case (opcode)
      OPC_OP: begin
        dec_d1 = bus.RS1_DATA;
        dec_d2 = bus.RS2_DATA;
        case (funct7)
          7'b0000000: begin
            dec_ok = 1'b1;
            case (funct3)
              3'b000:  dec_sel = SEL_ADD;
              3'b001:  dec_sel = SEL_SLL;
              3'b100:  dec_sel = SEL_XOR;
              3'b101:  dec_sel = SEL_SRL;
              3'b110:  dec_sel = SEL_OR;
              3'b111:  dec_sel = SEL_AND;
              default: dec_ok  = 1'b0;
            endcase
          end
          7'b0100000: begin
            if (funct3 == 3'b000) begin
              dec_ok  = 1'b1;
              dec_sel = SEL_ADD;
              dec_d2  = ~bus.RS2_DATA + 32'd1;
            end else if (funct3 == 3'b101) begin
              dec_ok  = 1'b1;
              dec_sel = SEL_SRA;
            end
          end
`ifdef ALU_ISSUE_MUL_EN
          7'b0000001: begin
            if (funct3 == 3'b000) begin
              dec_ok  = 1'b1;
              dec_sel = SEL_MUL;
              dec_mul = 1'b1;
            end
          end
`endif
          default: ;
        endcase
      end
      OPC_OPIMM: begin
        dec_d1 = bus.RS1_DATA;
        dec_d2 = imm_i;
        case (funct3)
          3'b000: begin dec_ok = 1'b1; dec_sel = SEL_ADD; end
          3'b100: begin dec_ok = 1'b1; dec_sel = SEL_XOR; end
          3'b110: begin dec_ok = 1'b1; dec_sel = SEL_OR;  end
          3'b111: begin dec_ok = 1'b1; dec_sel = SEL_AND; end
          3'b001: begin
            dec_d2 = shamt;
            if (funct7 == 7'b0000000) begin dec_ok = 1'b1; dec_sel = SEL_SLL; end
          end
          3'b101: begin
            dec_d2 = shamt;
            if (funct7 == 7'b0000000) begin
              dec_ok  = 1'b1;
              dec_sel = SEL_SRL;
            end else if (funct7 == 7'b0100000) begin
              dec_ok  = 1'b1;
              dec_sel = SEL_SRA;
            end
          end
          default: ;
        endcase
      end
      OPC_LUI: begin
        dec_ok  = 1'b1;
        dec_sel = SEL_FWD;
        dec_d2  = imm_u;
      end
      OPC_AUIPC: begin
        dec_ok  = 1'b1;
        dec_sel = SEL_ADD;
        dec_d1  = bus.PC;
        dec_d2  = imm_u;
      end
      default: ;
    endcase
    // Unsupported encodings still flow through the stage, but with zeroed operands.
    if (!dec_ok) begin
      dec_sel = SEL_FWD;
      dec_d1  = '0;
      dec_d2  = '0;
`ifdef ALU_ISSUE_MUL_EN
      dec_mul = 1'b0;
`endif
    end
  end

  state_t      state_q, state_d;
  logic        valid_q, valid_d;
  logic [31:0] data1_q, data1_d;
  logic [31:0] data2_q, data2_d;
  logic [3:0]  sel_q,   sel_d;
  logic [4:0]  rd_q,    rd_d;
  logic        wb_q,    wb_d;
  logic        ill_q,   ill_d;
  logic        in_ready;
  logic        accept;
`ifdef ALU_ISSUE_MUL_EN
  logic [3:0]  cnt_q,   cnt_d;
`endif

  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    data1_d  = data1_q;
    data2_d  = data2_q;
    sel_d    = sel_q;
    rd_d     = rd_q;
    wb_d     = wb_q;
    ill_d    = ill_q;
`ifdef ALU_ISSUE_MUL_EN
    cnt_d    = cnt_q;
`endif
    in_ready = !FLUSH && ((state_q == IDLE) || ((state_q == HOLD) && bus.OUT_READY));
    accept   = bus.IN_VALID && in_ready;

    if (FLUSH) begin
      state_d = IDLE;
      valid_d = 1'b0;
`ifdef ALU_ISSUE_MUL_EN
      cnt_d   = '0;
`endif
    end else if (accept) begin
      data1_d = dec_d1;
      data2_d = dec_d2;
      sel_d   = dec_sel;
      rd_d    = bus.INSTR[11:7];
      wb_d    = dec_ok;
      ill_d   = !dec_ok;
`ifdef ALU_ISSUE_MUL_EN
      if (dec_mul && (MUL_LATENCY > 1)) begin
        state_d = MWAIT;
        valid_d = 1'b0;
        cnt_d   = CNT_LOAD;
      end else
`endif
      begin
        state_d = HOLD;
        valid_d = 1'b1;
      end
    end else begin
      case (state_q)
        HOLD: begin
          if (bus.OUT_READY) begin
            state_d = IDLE;
            valid_d = 1'b0;
          end
        end
`ifdef ALU_ISSUE_MUL_EN
        // Leaving on the zero count (not one) lands OUT_VALID exactly MUL_LATENCY edges after accept.
        MWAIT: begin
          if (cnt_q == 4'd0) begin
            state_d = HOLD;
            valid_d = 1'b1;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      data1_q <= '0;
      data2_q <= '0;
      sel_q   <= '0;
      rd_q    <= '0;
      wb_q    <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      data1_q <= data1_d;
      data2_q <= data2_d;
      sel_q   <= sel_d;
      rd_q    <= rd_d;
      wb_q    <= wb_d;
      ill_q   <= ill_d;
    end
  end

`ifdef ALU_ISSUE_MUL_EN
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  assign bus.IN_READY  = in_ready;
  assign bus.OUT_VALID = valid_q;
  assign bus.DATA1     = data1_q;
  assign bus.DATA2     = data2_q;
  assign bus.SELECT    = sel_q;
  assign bus.RD        = rd_q;
  assign bus.WB_EN     = wb_q;
  assign bus.ILLEGAL   = ill_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed scoreboard bench for alu_issue_ctrl; MUL checks follow ALU_ISSUE_MUL_EN.
module tb_alu_issue_ctrl;

  logic CLK = 1'b0;
  logic RESETN;
  logic FLUSH;

  alu_issue_ctrl_if bus();

  alu_issue_ctrl #(.MUL_LATENCY(3)) dut (
    .CLK    (CLK),
    .RESETN (RESETN),
    .FLUSH  (FLUSH),
    .bus    (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0]  sel;
    logic [31:0] d1;
    bit          chk_d1;
    logic [31:0] d2;
    logic [4:0]  rd;
    logic        wb;
    logic        ill;
  } exp_t;

  exp_t        q[$];
  int unsigned n_checks = 0;
  int unsigned n_err    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic exp_t mk(input logic [3:0] sel, input logic [31:0] d1, input bit chk_d1,
                              input logic [31:0] d2, input logic [4:0] rd, input logic ill);
    exp_t e;
    e.sel = sel; e.d1 = d1; e.chk_d1 = chk_d1; e.d2 = d2; e.rd = rd;
    e.wb = !ill; e.ill = ill;
    return e;
  endfunction

  function automatic logic [31:0] r_ins(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rd);
    return {f7, 5'd2, 5'd1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] i_ins(input logic [11:0] imm, input logic [2:0] f3, input logic [4:0] rd);
    return {imm, 5'd1, f3, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] u_ins(input logic [19:0] imm, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rd, op};
  endfunction

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [31:0] pc);
    bus.INSTR    = instr;
    bus.RS1_DATA = rs1;
    bus.RS2_DATA = rs2;
    bus.PC       = pc;
    bus.IN_VALID = 1'b1;
  endtask

  // Waits (bounded) for IN_READY, records the expectation, then crosses the accepting edge.
  task automatic accept(input string tag, input exp_t e);
    int n = 0;
    #1;
    while (bus.IN_READY !== 1'b1 && n < 20) begin
      tick();
      #1;
      n++;
    end
    chk({tag, "_in_ready"}, 32'(bus.IN_READY), 32'd1);
    q.push_back(e);
    tick();
  endtask

  task automatic cmp_fields(input string tag, input exp_t e);
    chk({tag, "_sel"}, 32'(bus.SELECT), 32'(e.sel));
    if (e.chk_d1) chk({tag, "_data1"}, bus.DATA1, e.d1);
    chk({tag, "_data2"}, bus.DATA2, e.d2);
    chk({tag, "_rd"}, 32'(bus.RD), 32'(e.rd));
    chk({tag, "_wb_en"}, 32'(bus.WB_EN), 32'(e.wb));
    chk({tag, "_illegal"}, 32'(bus.ILLEGAL), 32'(e.ill));
  endtask

  task automatic cmp_out(input string tag);
    exp_t e;
    chk({tag, "_out_valid"}, 32'(bus.OUT_VALID), 32'd1);
    if (q.size() == 0) begin
      n_checks++;
      n_err++;
      $error("FAIL %s_sb: observed=empty-queue expected=entry", tag);
    end else begin
      e = q.pop_front();
      cmp_fields(tag, e);
    end
  endtask

  task automatic one(input string tag, input logic [31:0] instr, input logic [31:0] rs1,
                     input logic [31:0] rs2, input logic [31:0] pc, input exp_t e);
    drive(instr, rs1, rs2, pc);
    accept(tag, e);
    bus.IN_VALID = 1'b0;
    cmp_out(tag);
    tick();
    chk({tag, "_drain"}, 32'(bus.OUT_VALID), 32'd0);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_valid"}, 32'(bus.OUT_VALID), 32'd0);
    chk({tag, "_data1"}, bus.DATA1, 32'd0);
    chk({tag, "_data2"}, bus.DATA2, 32'd0);
    chk({tag, "_sel"}, 32'(bus.SELECT), 32'd0);
    chk({tag, "_rd"}, 32'(bus.RD), 32'd0);
    chk({tag, "_wb_en"}, 32'(bus.WB_EN), 32'd0);
    chk({tag, "_illegal"}, 32'(bus.ILLEGAL), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t ea, eb, dummy;
    RESETN        = 1'b0;
    FLUSH         = 1'b0;
    bus.IN_VALID  = 1'b0;
    bus.INSTR     = '0;
    bus.RS1_DATA  = '0;
    bus.RS2_DATA  = '0;
    bus.PC        = '0;
    bus.OUT_READY = 1'b1;
    repeat (2) @(negedge CLK);
    #1;
    chk_reset_outs("rst");
    @(negedge CLK);
    RESETN = 1'b1;
    tick();
    #1;
    chk("rst_in_ready", 32'(bus.IN_READY), 32'd1);

    one("add", r_ins(7'b0000000, 3'b000, 5'd3), 32'd10, 32'd20, 32'd0,
        mk(4'b0001, 32'd10, 1, 32'd20, 5'd3, 1'b0));
    one("sub", r_ins(7'b0100000, 3'b000, 5'd3), 32'd10, 32'd20, 32'd0,
        mk(4'b0001, 32'd10, 1, 32'hFFFF_FFEC, 5'd3, 1'b0));
    one("xor", r_ins(7'b0000000, 3'b100, 5'd4), 32'hF0F0_1234, 32'h0FF0_4321, 32'd0,
        mk(4'b0110, 32'hF0F0_1234, 1, 32'h0FF0_4321, 5'd4, 1'b0));
    one("addi", i_ins(12'hFFF, 3'b000, 5'd5), 32'd5, 32'd99, 32'd0,
        mk(4'b0001, 32'd5, 1, 32'hFFFF_FFFF, 5'd5, 1'b0));
    one("srai", i_ins({7'b0100000, 5'd4}, 3'b101, 5'd6), 32'h8000_0000, 32'd99, 32'd0,
        mk(4'b1001, 32'h8000_0000, 1, 32'd4, 5'd6, 1'b0));
    one("lui", u_ins(20'h12345, 5'd7, 7'b0110111), 32'd1, 32'd2, 32'd0,
        mk(4'b0000, 32'd0, 0, 32'h1234_5000, 5'd7, 1'b0));
    one("auipc", u_ins(20'hABCDE, 5'd8, 7'b0010111), 32'd1, 32'd2, 32'h0000_1000,
        mk(4'b0001, 32'h0000_1000, 1, 32'hABCD_E000, 5'd8, 1'b0));
    one("slt", r_ins(7'b0000000, 3'b010, 5'd9), 32'd10, 32'd20, 32'd0,
        mk(4'b0000, 32'd0, 1, 32'd0, 5'd9, 1'b1));
    one("add_x0", r_ins(7'b0000000, 3'b000, 5'd0), 32'd1, 32'd1, 32'd0,
        mk(4'b0001, 32'd1, 1, 32'd1, 5'd0, 1'b0));

`ifdef ALU_ISSUE_MUL_EN
    drive(r_ins(7'b0000001, 3'b000, 5'd4), 32'd7, 32'd6, 32'd0);
    accept("mul", mk(4'b0101, 32'd7, 1, 32'd6, 5'd4, 1'b0));
    bus.IN_VALID = 1'b0;
    chk("mul_valid_e0", 32'(bus.OUT_VALID), 32'd0);
    chk("mul_rdy_e0", 32'(bus.IN_READY), 32'd0);
    tick();
    chk("mul_valid_e1", 32'(bus.OUT_VALID), 32'd0);
    chk("mul_rdy_e1", 32'(bus.IN_READY), 32'd0);
    tick();
    chk("mul_valid_e2", 32'(bus.OUT_VALID), 32'd0);
    chk("mul_rdy_e2", 32'(bus.IN_READY), 32'd0);
    tick();
    cmp_out("mul_e3");
    tick();
    chk("mul_drain", 32'(bus.OUT_VALID), 32'd0);
`else
    one("mul_off", r_ins(7'b0000001, 3'b000, 5'd4), 32'd7, 32'd6, 32'd0,
        mk(4'b0000, 32'd0, 1, 32'd0, 5'd4, 1'b1));
`endif

    // Backpressure: A held four cycles while B waits, then A drains and B enters on the same edge.
    bus.OUT_READY = 1'b0;
    ea = mk(4'b0011, 32'd3, 1, 32'd5, 5'd10, 1'b0);
    eb = mk(4'b0010, 32'h0000_FF00, 1, 32'h0000_0FF0, 5'd11, 1'b0);
    drive(r_ins(7'b0000000, 3'b110, 5'd10), 32'd3, 32'd5, 32'd0);
    accept("bp_a", ea);
    drive(r_ins(7'b0000000, 3'b111, 5'd11), 32'h0000_FF00, 32'h0000_0FF0, 32'd0);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp_in_ready", 32'(bus.IN_READY), 32'd0);
      chk("bp_valid", 32'(bus.OUT_VALID), 32'd1);
      cmp_fields("bp_hold", q[0]);
      tick();
    end
    bus.OUT_READY = 1'b1;
    #1;
    chk("bp_in_ready_go", 32'(bus.IN_READY), 32'd1);
    cmp_out("bp_a");
    q.push_back(eb);
    tick();
    bus.IN_VALID = 1'b0;
    cmp_out("bp_b");
    tick();
    chk("bp_drain", 32'(bus.OUT_VALID), 32'd0);

    // FLUSH in HOLD with a bundle still offered: nothing may be accepted on the flush edge.
    bus.OUT_READY = 1'b0;
    drive(r_ins(7'b0000000, 3'b000, 5'd12), 32'd1, 32'd2, 32'd0);
    accept("fl_hold", mk(4'b0001, 32'd1, 1, 32'd2, 5'd12, 1'b0));
    cmp_out("fl_hold");
    FLUSH = 1'b1;
    #1;
    chk("fl_in_ready", 32'(bus.IN_READY), 32'd0);
    tick();
    chk("fl_hold_valid", 32'(bus.OUT_VALID), 32'd0);
    FLUSH = 1'b0;
    bus.IN_VALID = 1'b0;
    bus.OUT_READY = 1'b1;
    #1;
    chk("fl_idle_rdy", 32'(bus.IN_READY), 32'd1);
    tick();
    chk("fl_no_accept", 32'(bus.OUT_VALID), 32'd0);

`ifdef ALU_ISSUE_MUL_EN
    drive(r_ins(7'b0000001, 3'b000, 5'd13), 32'd3, 32'd4, 32'd0);
    accept("fl_mwait", mk(4'b0101, 32'd3, 1, 32'd4, 5'd13, 1'b0));
    dummy = q.pop_back();
    bus.IN_VALID = 1'b0;
    tick();
    FLUSH = 1'b1;
    tick();
    FLUSH = 1'b0;
    chk("fl_mwait_valid", 32'(bus.OUT_VALID), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("fl_mwait_quiet", 32'(bus.OUT_VALID), 32'd0);
    end

    drive(r_ins(7'b0000001, 3'b000, 5'd14), 32'd9, 32'd8, 32'd0);
    accept("rst_mwait", mk(4'b0101, 32'd9, 1, 32'd8, 5'd14, 1'b0));
    dummy = q.pop_back();
    bus.IN_VALID = 1'b0;
    tick();
    RESETN = 1'b0;
    #1;
    chk_reset_outs("rst_mwait");
    @(negedge CLK);
    RESETN = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rst_mwait_quiet", 32'(bus.OUT_VALID), 32'd0);
    end
`endif

    bus.OUT_READY = 1'b0;
    drive(r_ins(7'b0100000, 3'b101, 5'd15), 32'h8000_0000, 32'd3, 32'd0);
    accept("rst_hold", mk(4'b1001, 32'h8000_0000, 1, 32'd3, 5'd15, 1'b0));
    bus.IN_VALID = 1'b0;
    cmp_out("rst_hold");
    RESETN = 1'b0;
    #1;
    chk_reset_outs("rst_hold_async");
    @(negedge CLK);
    RESETN = 1'b1;
    bus.OUT_READY = 1'b1;
    tick();
    chk("rst_hold_quiet", 32'(bus.OUT_VALID), 32'd0);

    chk("sb_empty", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
